// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// state encoding, field widths and the running-checksum helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    localparam int HDR_W      = 16;
    localparam int CSUM_W     = 8;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int ADDR_W_DEF = 13;
    localparam int DEPTH_DEF  = 8192;

    // Fold one payload byte into the running XOR checksum.
    function automatic logic [CSUM_W-1:0] csum_update(input logic [CSUM_W-1:0] acc,
                                                      input logic [BYTE_W-1:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; word_valid_o pulses
// for one cycle after the fourth byte, word_o holds until the next word.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              last_byte_o,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [1:0]        pos_q, pos_d;
    logic [23:0]       sr_q, sr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    assign last_byte_o  = byte_valid_i && (pos_q == 2'd3);
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

    // Shift bytes in MSB-first; the fourth byte completes the word.
    always_comb begin
        pos_d   = pos_q;
        sr_d    = sr_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clr_i) begin
            pos_d = 2'd0;
            sr_d  = 24'd0;
        end else if (byte_valid_i) begin
            pos_d = pos_q + 2'd1;
            if (pos_q == 2'd3) begin
                word_d  = {sr_q, byte_i};
                valid_d = 1'b1;
            end else begin
                sr_d = {sr_q[15:0], byte_i};
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Assembler state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q   <= 2'd0;
            sr_q    <= 24'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a header + big-endian payload + XOR checksum image into instruction
// memory and holds the CPU in reset until a verified image is in place.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [HDR_W-1:0] DEPTH_L = HDR_W'(DEPTH);

    state_e              state_q, state_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [HDR_W-1:0]    remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic                cpu_reset_q, done_q, error_q;
    logic                accept_s, restart_s, byte_in_s, word_last_s, word_valid_s;
    logic [HDR_W-1:0]    hdr_s;
    logic [WORD_W-1:0]   word_s;

    assign rx_ready  = (state_q != S_DONE) && (state_q != S_ERR);
    assign accept_s  = rx_valid && rx_ready;
    assign restart_s = start && ((state_q == S_DONE) || (state_q == S_ERR));
    assign byte_in_s = accept_s && (state_q == S_DATA);
    assign hdr_s     = {cnt_hi_q, rx_data};

    word_assembler u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (restart_s),
        .byte_valid_i (byte_in_s),
        .byte_i       (rx_data),
        .last_byte_o  (word_last_s),
        .word_valid_o (word_valid_s),
        .word_o       (word_s)
    );

    assign imem_wr_en   = word_valid_s;
    assign imem_wr_data = word_s;
    assign imem_wr_addr = wr_addr_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;

    // Header parse, payload word counting, checksum compare and restart.
    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        wr_addr_d   = wr_addr_q;
        csum_d      = csum_q;
        case (state_q)
            S_HDR_HI: begin
                if (accept_s) begin
                    cnt_hi_d = rx_data;
                    state_d  = S_HDR_LO;
                end else begin
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_LO: begin
                if (accept_s) begin
                    remaining_d = hdr_s;
                    if (hdr_s > DEPTH_L) begin
                        state_d = S_ERR;
                    end else if (hdr_s == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_HDR_LO;
                end
            end
            S_DATA: begin
                if (byte_in_s) begin
                    csum_d = csum_update(csum_q, rx_data);
                    if (word_last_s) begin
                        wr_addr_d   = addr_q;
                        addr_d      = addr_q + ADDR_W'(1);
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (accept_s) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_DONE, S_ERR: begin
                if (restart_s) begin
                    state_d = S_HDR_HI;
                    addr_d  = '0;
                    csum_d  = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State and status registers; status follows the next state so it
    // changes in the same cycle as the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_HDR_HI;
            cnt_hi_q    <= 8'd0;
            remaining_q <= 16'd0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            csum_q      <= 8'd0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wr_addr_q   <= wr_addr_d;
            csum_q      <= csum_d;
            cpu_reset_q <= (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: streams images (directed and random)
// and compares writes and status against an image-level reference model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, imem_wr_en, cpu_reset, done, error;
    logic [12:0] imem_wr_addr;
    logic [31:0] imem_wr_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  stream_q[$];
    logic [44:0] got_q[$];
    longint      got_t[$];
    longint      cyc = 0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe seen between clock edges.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            got_q.push_back({imem_wr_addr, imem_wr_data});
            got_t.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".rx_ready"}, 32'(rx_ready), 32'd1);
        check_eq({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
        check_eq({tag, ".wr_en"}, 32'(imem_wr_en), 32'd0);
        check_eq({tag, ".wr_addr"}, 32'(imem_wr_addr), 32'd0);
        check_eq({tag, ".wr_data"}, imem_wr_data, 32'd0);
        check_eq({tag, ".done"}, 32'(done), 32'd0);
        check_eq({tag, ".error"}, 32'(error), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        n = gaps ? int'($urandom_range(0, 3)) : 0;
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            start    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq({tag, ".start_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check_eq({tag, ".start_rx_ready"}, 32'(rx_ready), 32'd1);
        check_eq({tag, ".start_done"}, 32'(done), 32'd0);
        check_eq({tag, ".start_error"}, 32'(error), 32'd0);
    endtask

    // Reference: decode the image as a whole, then compare the outcome.
    task automatic run_stream(input string tag, input bit gaps);
        logic [44:0] exp_q[$];
        int          cnt;
        logic [7:0]  cs;
        logic [31:0] w;
        bit          exp_done, exp_err;
        cnt = {stream_q[0], stream_q[1]};
        cs  = 8'd0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (cnt > 8192) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < cnt; i++) begin
                w = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    w  = (w << 8) | 32'(stream_q[2 + 4*i + k]);
                    cs = cs ^ stream_q[2 + 4*i + k];
                end
                exp_q.push_back({13'(i), w});
            end
            exp_done = (stream_q[2 + 4*cnt] == cs);
            exp_err  = !exp_done;
        end
        got_q.delete();
        got_t.delete();
        foreach (stream_q[i]) send_byte(stream_q[i], gaps);
        @(negedge clk);
        check_eq({tag, ".done"}, 32'(done), 32'(exp_done));
        check_eq({tag, ".error"}, 32'(error), 32'(exp_err));
        check_eq({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check_eq({tag, ".rx_ready"}, 32'(rx_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, ".nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq($sformatf("%s.addr%0d", tag, i), 32'(got_q[i][44:32]), 32'(exp_q[i][44:32]));
            check_eq($sformatf("%s.data%0d", tag, i), got_q[i][31:0], exp_q[i][31:0]);
            if (!gaps && i > 0) begin
                check_eq($sformatf("%s.spacing%0d", tag, i), 32'(got_t[i] - got_t[i-1]), 32'd4);
            end
        end
    endtask

    task automatic load_example(input logic [7:0] csum);
        logic [7:0] img[11];
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h00};
        img[10] = csum;
        stream_q.delete();
        foreach (img[i]) stream_q.push_back(img[i]);
    endtask

    initial begin
        int         n;
        logic [7:0] cs;
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b1;

        // Example image; the XOR of its payload bytes is 0x55.
        load_example(8'h55);
        run_stream("img_ok", 1'b0);
        pulse_start("s1");

        load_example(8'h00);
        run_stream("img_badcs", 1'b0);
        pulse_start("s2");

        stream_q = '{8'h20, 8'h01};
        run_stream("too_big", 1'b0);
        pulse_start("s3");

        stream_q = '{8'h00, 8'h00, 8'h00};
        run_stream("empty", 1'b0);
        pulse_start("s4");

        // Abandon a load mid-word with reset.
        got_q.delete();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst.nwrites", 32'(got_q.size()), 32'd0);
        stream_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        run_stream("deadbeef", 1'b0);
        pulse_start("s5");

        load_example(8'h55);
        run_stream("img_gaps", 1'b1);

        for (int r = 0; r < 6; r++) begin
            pulse_start($sformatf("rs%0d", r));
            n  = int'($urandom_range(0, 5));
            cs = 8'd0;
            stream_q.delete();
            stream_q.push_back(8'd0);
            stream_q.push_back(8'(n));
            for (int i = 0; i < 4 * n; i++) begin
                stream_q.push_back(8'($urandom));
                cs = cs ^ stream_q[stream_q.size() - 1];
            end
            if ($urandom_range(0, 2) == 0) cs = cs ^ 8'(1 + $urandom_range(0, 254));
            stream_q.push_back(cs);
            run_stream($sformatf("rnd%0d", r), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
